bus_gate_arbiter: RTL and testbench
===================================

BUS_GATE_ARBITER -- requirements
Module: bus_gate_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive bus-owner cycles before preemption when another requester waits; legal range 1..7.
REQ-002 Port: clock  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  5  bus requests, level-sensitive; bit0=PC, bit1=MDR, bit2=ALU, bit3=MARMUX, bit4=SHF.
REQ-005 Port: gate  output  5  registered gate enables to the per-source bus tri-state gates, same bit order as req.
REQ-006 Port: owner  output  3  encoded index of current owner, 0..4; 3'b111 when no owner.
REQ-007 Port: busy  output  1  high when any gate bit is high.

Function
REQ-008 gate SHALL always be one-hot or all-zero; two sources SHALL never drive the bus in the same cycle.
REQ-009 Block SHALL be a three-state machine: IDLE, OWN, TURN.
REQ-010 Internal state SHALL comprise: rotating priority pointer ptr (0..4), hold counter hcnt (3 bits), and current-owner register.
REQ-011 Winner selection SHALL scan req circularly starting at ptr; the first set bit wins.
REQ-012 IDLE: if any req bit is high at a rising edge, next state SHALL be OWN with gate set to the winner; otherwise the block stays in IDLE with gate=0.
REQ-013 Request-to-gate latency from IDLE SHALL be exactly one clock (req sampled at edge N, gate high after edge N).
REQ-014 On entering OWN, hcnt SHALL load 1; each further OWN cycle increments hcnt, saturating at 7.
REQ-015 OWN -> TURN SHALL occur when the owner's req bit is low at the edge; gate clears at that edge.
REQ-016 OWN -> TURN SHALL also occur when hcnt >= MAX_HOLD and any other req bit is high (preemption), even if the owner still requests.
REQ-017 If the owner still requests, hcnt >= MAX_HOLD, and no other bit is high, the block SHALL remain in OWN.
REQ-018 On every OWN -> TURN transition, ptr SHALL update to (owner+1) mod 5.
REQ-019 TURN SHALL last exactly one cycle with gate=0, busy=0, and owner=3'b111 (bus turnaround).
REQ-020 TURN: if any req bit is high, next state SHALL be OWN with the winner per REQ-011 using the updated ptr; otherwise IDLE.
REQ-021 A req pulse that is high only between edges SHALL be ignored.
REQ-022 owner and busy SHALL be registered consistently with gate in the same cycle.

Reset
REQ-023 While reset is high, and asynchronously on its assertion, the block SHALL force state=IDLE, gate=5'b00000, owner=3'b111, busy=0, hcnt=0, ptr=0.
REQ-024 Reset asserted during OWN SHALL clear gate without waiting for a clock edge.
REQ-025 After reset deassertion, the first grant SHALL follow REQ-012 with ptr=0.

Verification
REQ-026 Reset, then req=5'b00001 held -> gate=5'b00001, owner=0, busy=1 one edge later; gate stays high while req is held and no other request.
REQ-027 req=5'b00101 from IDLE with ptr=0 -> PC owns; PC drops after 2 cycles -> one TURN cycle with gate=0, then gate=5'b00100, owner=2.
REQ-028 MAX_HOLD=4, PC and MDR held high continuously -> PC owns 4 cycles, TURN 1 cycle, MDR owns 4 cycles, TURN 1 cycle, PC again; gate never multi-hot.
REQ-029 All five req bits held high -> ownership order 0,1,2,3,4,0 (wrap-around), each tenure MAX_HOLD cycles separated by single TURN cycles.
REQ-030 Reset asserted mid-OWN between edges -> gate=0, owner=3'b111 immediately; after release with req=5'b10000 -> gate=5'b10000 one edge later.

Source files
------------

// File: rtl/bus_gate_arbiter_if.sv
// Bus request/gate bundle between the bus sources and the gate arbiter.
// The arbiter connects through the slave modport; requesters use master.
interface bus_gate_arbiter_if;
    logic [4:0] req;
    logic [4:0] gate;
    logic [2:0] owner;
    logic       busy;

    modport master (output req, input gate, input owner, input busy);
    modport slave  (input req, output gate, output owner, output busy);
endinterface

// File: rtl/bus_gate_arbiter.sv
// Round-robin arbiter for five bus sources with hold-time preemption and a
// one-cycle turnaround between owners; gate, owner and busy are registered.
module bus_gate_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic               clock,
    input  logic               reset,
    bus_gate_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t     state_reg;
    logic [2:0] ptr_reg;
    logic [2:0] hcnt_reg;
    logic [2:0] owner_reg;
    logic [4:0] gate_reg;
    logic       busy_reg;

    logic [2:0] idx_at [5];
    logic [4:0] rot_req;
    logic [2:0] winner;
    logic       any_req;
    logic       owner_req;
    logic       other_req;
    logic       hold_done;
    logic [2:0] ptr_next;

    // rot_req[k] is the request of the source k positions after ptr.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_rot
            logic [3:0] sum;
            assign sum          = {1'b0, ptr_reg} + 4'(gi);
            assign idx_at[gi]   = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
            assign rot_req[gi]  = bus.req[idx_at[gi]];
        end
    endgenerate

    always_comb begin
        winner = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (rot_req[k]) begin
                winner = idx_at[k];
            end
        end
    end

    assign any_req   = |bus.req;
    assign owner_req = |(bus.req & gate_reg);
    assign other_req = |(bus.req & ~gate_reg);
    assign hold_done = (hcnt_reg >= 3'(MAX_HOLD));
    assign ptr_next  = (owner_reg == 3'd4) ? 3'd0 : owner_reg + 3'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 3'd0;
            hcnt_reg  <= 3'd0;
            owner_reg <= 3'b111;
            gate_reg  <= 5'b00000;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, TURN: begin
                    if (any_req) begin
                        state_reg <= OWN;
                        gate_reg  <= 5'd1 << winner;
                        owner_reg <= winner;
                        busy_reg  <= 1'b1;
                        hcnt_reg  <= 3'd1;
                    end else begin
                        state_reg <= IDLE;
                        gate_reg  <= 5'b00000;
                        owner_reg <= 3'b111;
                        busy_reg  <= 1'b0;
                    end
                end
                OWN: begin
                    // Release on owner drop, or preempt once the hold budget is spent.
                    if (!owner_req || (hold_done && other_req)) begin
                        state_reg <= TURN;
                        gate_reg  <= 5'b00000;
                        owner_reg <= 3'b111;
                        busy_reg  <= 1'b0;
                        ptr_reg   <= ptr_next;
                    end else if (hcnt_reg != 3'd7) begin
                        hcnt_reg <= hcnt_reg + 3'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    gate_reg  <= 5'b00000;
                    owner_reg <= 3'b111;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gate  = gate_reg;
    assign bus.owner = owner_reg;
    assign bus.busy  = busy_reg;
endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Directed and randomized checks of bus_gate_arbiter against a tenure-level
// reference model (current owner, tenure length, turnaround flag, pointer).
module tb_bus_gate_arbiter;
    localparam int MH = 4;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bus_gate_arbiter_if bus ();

    bus_gate_arbiter #(.MAX_HOLD(MH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: who holds the bus and for how long.
    int m_owner;   // -1 when nobody owns
    bit m_turn;
    int m_tenure;
    int m_ptr;

    task automatic model_reset();
        m_owner  = -1;
        m_turn   = 1'b0;
        m_tenure = 0;
        m_ptr    = 0;
    endtask

    function automatic int pick(input logic [4:0] r, input int p);
        for (int k = 0; k < 5; k++) begin
            if (r[(p + k) % 5]) return (p + k) % 5;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [4:0] r);
        if (m_owner < 0) begin
            m_turn = 1'b0;
            if (r != 5'b0) begin
                m_owner  = pick(r, m_ptr);
                m_tenure = 1;
            end
        end else begin
            logic [4:0] others;
            others = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner] || (m_tenure >= MH && others != 5'b0)) begin
                m_ptr   = (m_owner + 1) % 5;
                m_owner = -1;
                m_turn  = 1'b1;
            end else begin
                m_tenure++;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_model(input string tag);
        logic [4:0] eg;
        logic [2:0] eo;
        eg = (m_owner < 0) ? 5'b0 : (5'b1 << m_owner);
        eo = (m_owner < 0) ? 3'b111 : 3'(m_owner);
        chk({tag, ".gate"},  8'(bus.gate),  8'(eg));
        chk({tag, ".owner"}, 8'(bus.owner), 8'(eo));
        chk({tag, ".busy"},  8'(bus.busy),  8'(m_owner >= 0));
        chk({tag, ".onehot"}, 8'($countones(bus.gate) <= 1), 8'd1);
    endtask

    // Called just after an edge; applies req, clocks once, then checks.
    task automatic cycle(input logic [4:0] r, input string tag);
        bus.req = r;
        @(posedge clock);
        model_step(r);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 5'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        reset   = 1'b1;
        bus.req = 5'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst.gate",  8'(bus.gate),  8'h00);
        chk("rst.owner", 8'(bus.owner), 8'h07);
        chk("rst.busy",  8'(bus.busy),  8'h00);
        reset = 1'b0;

        // Single requester held.
        cycle(5'b00001, "pc_first");
        chk("pc_first.const", 8'({bus.gate, bus.owner}), 8'({5'b00001, 3'd0}));
        for (int i = 0; i < 6; i++) cycle(5'b00001, "pc_hold");
        chk("pc_hold.const", 8'(bus.gate), 8'h01);

        // Pulse between edges from IDLE is ignored.
        cycle(5'b00000, "pc_drop");
        cycle(5'b00000, "idle");
        bus.req = 5'b00010;
        #3;
        bus.req = 5'b00000;
        #1;
        cycle(5'b00000, "pulse");
        chk("pulse.const", 8'(bus.gate), 8'h00);

        // PC and ALU from IDLE with ptr=0; PC drops after two cycles.
        do_reset();
        cycle(5'b00101, "pcalu1");
        chk("pcalu1.owner", 8'(bus.owner), 8'd0);
        cycle(5'b00101, "pcalu2");
        cycle(5'b00100, "pcalu_turn");
        chk("pcalu_turn.gate", 8'(bus.gate), 8'h00);
        cycle(5'b00100, "alu_own");
        chk("alu_own.const", 8'({bus.gate, bus.owner}), 8'({5'b00100, 3'd2}));

        // PC and MDR held: period MH owner cycles + 1 turnaround.
        do_reset();
        for (int i = 0; i < 3 * 2 * (MH + 1); i++) begin
            int pos;
            cycle(5'b00011, "pcmdr");
            pos = i % (2 * (MH + 1));
            chk("pcmdr.seq", 8'(bus.owner),
                8'((pos < MH) ? 0 : (pos == MH) ? 7 : (pos < 2 * MH + 1) ? 1 : 7));
        end

        // All five held: order 0..4 then wrap.
        do_reset();
        for (int i = 0; i < 6 * (MH + 1); i++) begin
            int pos;
            cycle(5'b11111, "all5");
            pos = i % (5 * (MH + 1));
            chk("all5.seq", 8'(bus.owner),
                8'(((pos % (MH + 1)) < MH) ? (pos / (MH + 1)) : 7));
        end

        // Asynchronous reset in the middle of a tenure.
        do_reset();
        cycle(5'b00001, "pre_rst");
        cycle(5'b00001, "pre_rst");
        #2;
        reset = 1'b1;
        #1;
        chk("async.gate",  8'(bus.gate),  8'h00);
        chk("async.owner", 8'(bus.owner), 8'h07);
        chk("async.busy",  8'(bus.busy),  8'h00);
        model_reset();
        bus.req = 5'b10000;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle(5'b10000, "post_rst");
        chk("post_rst.const", 8'({bus.gate, bus.owner}), 8'({5'b10000, 3'd4}));

        // Randomized segments of held request patterns.
        for (int s = 0; s < 40; s++) begin
            logic [4:0] pat;
            int len;
            pat = 5'($urandom_range(0, 31));
            len = $urandom_range(1, 12);
            for (int c = 0; c < len; c++) cycle(pat, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
